// File: rtl/mem_port_arb.sv
// Single-port SRAM arbiter between instruction fetch and load/store, one transaction in flight.
// Define ARB_STARVE_EN to let fetch win after STARVE_MAX consecutive contested losses.
module mem_port_arb #(
  parameter int RD_LAT     = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        ls_req,
  input  logic [3:0]  ls_we,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_gnt,
  output logic        ls_rvalid,
  output logic [31:0] ls_rdata,
  output logic        sram_en,
  output logic [3:0]  sram_we,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata,
  output logic        stallreq_if,
  output logic        stallreq_ls
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        ownerLs_q, ownerLs_d;
  logic [31:0] ifRdata_q, ifRdata_d;
  logic [31:0] lsRdata_q, lsRdata_d;
  logic        issue;
  logic        lsWins;
  logic        isStore;

  // Issue is suppressed while reset is held so the SRAM port stays quiet.
  assign issue   = (state_q == IDLE) & rst & (if_req | ls_req);
  assign isStore = lsWins & (ls_we != 4'b0000);

`ifdef ARB_STARVE_EN
  logic [3:0] starve_q, starve_d;

  assign lsWins = ls_req & ~(if_req & (starve_q == 4'(STARVE_MAX)));

  always_comb begin
    starve_d = starve_q;
    if (issue && !lsWins)
      starve_d = 4'd0;
    else if (issue && if_req)
      starve_d = starve_q + 4'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      starve_q <= 4'd0;
    else
      starve_q <= starve_d;
  end
`else
  assign lsWins = ls_req;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= 3'd0;
      ownerLs_q <= 1'b0;
      ifRdata_q <= 32'h0;
      lsRdata_q <= 32'h0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ownerLs_q <= ownerLs_d;
      ifRdata_q <= ifRdata_d;
      lsRdata_q <= lsRdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ownerLs_d = ownerLs_q;
    ifRdata_d = ifRdata_q;
    lsRdata_d = lsRdata_q;
    case (state_q)
      IDLE: begin
        if (issue) begin
          ownerLs_d = lsWins;
          cnt_d     = 3'(RD_LAT - 1);
          state_d   = isStore ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 3'd0) begin
          if (ownerLs_q)
            lsRdata_d = sram_rdata;
          else
            ifRdata_d = sram_rdata;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    if_gnt     = issue & ~lsWins;
    ls_gnt     = issue & lsWins;
    sram_en    = issue;
    sram_we    = 4'b0000;
    sram_addr  = 32'h0;
    sram_wdata = 32'h0;
    if (issue) begin
      if (lsWins) begin
        sram_we    = ls_we;
        sram_addr  = ls_addr;
        sram_wdata = ls_wdata;
      end else begin
        sram_addr  = if_addr;
      end
    end
    if_rvalid   = (state_q == RESP) & ~ownerLs_q;
    ls_rvalid   = (state_q == RESP) & ownerLs_q;
    if_rdata    = ifRdata_q;
    ls_rdata    = lsRdata_q;
    stallreq_if = if_req & ~if_rvalid;
    stallreq_ls = ls_req & ~ls_rvalid;
  end

endmodule

// File: tb/tb_mem_port_arb.sv
// Directed bench for mem_port_arb with a transaction-level reference model checked every cycle.
// Honours ARB_STARVE_EN the same way as the design.
module tb_mem_port_arb;
  localparam int RD_LAT     = 2;
  localparam int STARVE_MAX = 4;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        ls_req;
  logic [3:0]  ls_we;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_gnt;
  logic        ls_rvalid;
  logic [31:0] ls_rdata;
  logic        sram_en;
  logic [3:0]  sram_we;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic        stallreq_if;
  logic        stallreq_ls;

  int total = 0;
  int bad   = 0;
  int cycle = 0;

  mem_port_arb #(.RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .stallreq_if(stallreq_if), .stallreq_ls(stallreq_ls)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (a == 32'h0000_0100)
      return 32'hDEAD_BEEF;
    return (a ^ 32'h5A5A_0000) + 32'h0000_1111;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Reference model state: one outstanding transaction described by owner, kind and completion cycle.
  bit          mBusy = 0;
  bit          mOwnLs = 0;
  bit          mLoad = 0;
  int          mDone = 0;
  logic [31:0] mData = 32'h0;
  logic [31:0] mIfR = 32'h0;
  logic [31:0] mLsR = 32'h0;
  int          rdCycle = -1;
  logic [31:0] rdWord = 32'h0;
`ifdef ARB_STARVE_EN
  int          mStarve = 0;
`endif

  // SRAM read data appears only in the cycle RD_LAT after a load issue; other cycles carry junk.
  always @(posedge clk) begin
    cycle++;
    #1;
    sram_rdata = (cycle == rdCycle) ? rdWord : (32'hBAD0_0000 | 32'(cycle));
  end

  always @(negedge clk) begin
    bit          eIfRv, eLsRv, eIfG, eLsG, eEn, pickLs;
    logic [3:0]  eWe;
    logic [31:0] eAddr, eWd;
    eIfRv = 0; eLsRv = 0; eIfG = 0; eLsG = 0; eEn = 0; pickLs = 0;
    eWe = 4'b0; eAddr = 32'h0; eWd = 32'h0;
    if (!rst) begin
      mBusy = 0; mIfR = 32'h0; mLsR = 32'h0; rdCycle = -1;
`ifdef ARB_STARVE_EN
      mStarve = 0;
`endif
    end else if (mBusy && cycle == mDone) begin
      if (mOwnLs) begin
        eLsRv = 1;
        if (mLoad) mLsR = mData;
      end else begin
        eIfRv = 1;
        mIfR  = mData;
      end
      mBusy = 0;
    end else if (!mBusy && (if_req || ls_req)) begin
      pickLs = ls_req;
`ifdef ARB_STARVE_EN
      if (if_req && ls_req && mStarve == STARVE_MAX) pickLs = 0;
      if (!pickLs) mStarve = 0;
      else if (if_req) mStarve++;
`endif
      eEn = 1;
      mBusy = 1;
      mOwnLs = pickLs;
      if (pickLs) begin
        eLsG = 1; eWe = ls_we; eAddr = ls_addr; eWd = ls_wdata;
        mLoad = (ls_we == 4'b0000);
      end else begin
        eIfG = 1; eAddr = if_addr;
        mLoad = 1;
      end
      mDone = mLoad ? cycle + RD_LAT + 1 : cycle + 1;
      mData = memWord(eAddr);
      if (mLoad) begin
        rdCycle = cycle + RD_LAT;
        rdWord  = mData;
      end
    end
    checkOutput("if_gnt", 32'(if_gnt), 32'(eIfG));
    checkOutput("ls_gnt", 32'(ls_gnt), 32'(eLsG));
    checkOutput("sram_en", 32'(sram_en), 32'(eEn));
    checkOutput("sram_we", 32'(sram_we), 32'(eWe));
    checkOutput("sram_addr", sram_addr, eAddr);
    checkOutput("sram_wdata", sram_wdata, eWd);
    checkOutput("if_rvalid", 32'(if_rvalid), 32'(eIfRv));
    checkOutput("ls_rvalid", 32'(ls_rvalid), 32'(eLsRv));
    checkOutput("if_rdata", if_rdata, mIfR);
    checkOutput("ls_rdata", ls_rdata, mLsR);
    checkOutput("stallreq_if", 32'(stallreq_if), 32'(if_req & ~eIfRv));
    checkOutput("stallreq_ls", 32'(stallreq_ls), 32'(ls_req & ~eLsRv));
  end

  task automatic waitRvalid(input bit isLs);
    bit seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      seen = isLs ? ls_rvalid : if_rvalid;
    end
    checkOutput("rvalid_timeout", 32'(seen), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit isLs, input logic [3:0] we,
                               input logic [31:0] addr, input logic [31:0] wdata);
    @(posedge clk);
    #1;
    if (isLs) begin
      ls_req = 1; ls_we = we; ls_addr = addr; ls_wdata = wdata;
    end else begin
      if_req = 1; if_addr = addr;
    end
    waitRvalid(isLs);
    if (isLs) ls_req = 0; else if_req = 0;
  endtask

  initial begin
    int nLs, nIf;
    rst = 0; if_req = 0; if_addr = 0; ls_req = 0; ls_we = 0; ls_addr = 0; ls_wdata = 0;
    sram_rdata = 32'h0;
    repeat (3) @(negedge clk);
    checkOutput("rst_if_rdata", if_rdata, 32'h0);
    checkOutput("rst_ls_rdata", ls_rdata, 32'h0);
    checkOutput("rst_sram_en", 32'(sram_en), 32'd0);
    @(posedge clk); #1 rst = 1;

    // Basic fetch with pinned latency and data.
    @(posedge clk); #1 if_req = 1; if_addr = 32'h0000_0100;
    @(negedge clk);
    checkOutput("fetch_gnt", 32'(if_gnt), 32'd1);
    checkOutput("fetch_addr", sram_addr, 32'h0000_0100);
    repeat (3) @(negedge clk);
    checkOutput("fetch_rvalid_T3", 32'(if_rvalid), 32'd1);
    checkOutput("fetch_rdata_T3", if_rdata, 32'hDEAD_BEEF);
    @(posedge clk); #1 if_req = 0;

    // Contested: store goes first, fetch two cycles later.
    @(posedge clk); #1;
    if_req = 1; if_addr = 32'h0000_0400;
    ls_req = 1; ls_we = 4'b0011; ls_addr = 32'h0000_0800; ls_wdata = 32'h1234_5678;
    @(negedge clk);
    checkOutput("contest_ls_gnt", 32'(ls_gnt), 32'd1);
    checkOutput("contest_if_gnt0", 32'(if_gnt), 32'd0);
    checkOutput("contest_we", 32'(sram_we), 32'h3);
    checkOutput("contest_wdata", sram_wdata, 32'h1234_5678);
    @(negedge clk);
    checkOutput("contest_ls_rvalid", 32'(ls_rvalid), 32'd1);
    @(posedge clk); #1 ls_req = 0;
    @(negedge clk);
    checkOutput("contest_if_gnt2", 32'(if_gnt), 32'd1);
    waitRvalid(1'b0);
    if_req = 0;

    // Both requests held for 20 cycles of stores versus fetches.
    @(posedge clk); #1;
    if_req = 1; if_addr = 32'h0000_0500;
    ls_req = 1; ls_we = 4'b1111; ls_addr = 32'h0000_0900; ls_wdata = 32'hCAFE_F00D;
    nLs = 0; nIf = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ls_gnt) nLs++;
      if (if_gnt) nIf++;
    end
    @(posedge clk); #1 if_req = 0; ls_req = 0;
`ifdef ARB_STARVE_EN
    checkOutput("starve_ls_grants", 32'(nLs), 32'd8);
    checkOutput("starve_if_grants", 32'(nIf), 32'd1);
`else
    checkOutput("strict_ls_grants", 32'(nLs), 32'd10);
    checkOutput("strict_if_grants", 32'(nIf), 32'd0);
`endif

    // Load whose request is withdrawn right after grant still completes.
    @(posedge clk); #1 ls_req = 1; ls_we = 4'b0000; ls_addr = 32'h0000_0200;
    @(negedge clk);
    checkOutput("drop_ls_gnt", 32'(ls_gnt), 32'd1);
    @(posedge clk); #1 ls_req = 0;
    repeat (3) @(negedge clk);
    checkOutput("drop_ls_rvalid", 32'(ls_rvalid), 32'd1);
    checkOutput("drop_ls_rdata", ls_rdata, 32'h5A5A_1311);
    @(negedge clk);
    checkOutput("drop_stallreq_ls", 32'(stallreq_ls), 32'd0);

    // Mixed traffic.
    applyStimulus(1'b0, 4'b0000, 32'h0000_1000, 32'h0);
    applyStimulus(1'b1, 4'b0000, 32'h0000_2004, 32'h0);
    applyStimulus(1'b1, 4'b1000, 32'h0000_3008, 32'h89AB_CDEF);
    applyStimulus(1'b0, 4'b0000, 32'hFFFF_FFFC, 32'h0);
    applyStimulus(1'b1, 4'b0000, 32'h0000_0003, 32'h0);

    // Reset in the middle of a fetch abandons it; the held request is granted after release.
    @(posedge clk); #1 if_req = 1; if_addr = 32'h0000_0300;
    @(negedge clk);
    checkOutput("mid_rst_gnt", 32'(if_gnt), 32'd1);
    @(posedge clk); #2 rst = 0;
    @(negedge clk);
    checkOutput("mid_rst_gnt0", 32'(if_gnt), 32'd0);
    checkOutput("mid_rst_en0", 32'(sram_en), 32'd0);
    checkOutput("mid_rst_if_rdata", if_rdata, 32'h0);
    checkOutput("mid_rst_ls_rdata", ls_rdata, 32'h0);
    repeat (2) begin
      @(negedge clk);
      checkOutput("mid_rst_no_rvalid", 32'(if_rvalid), 32'd0);
    end
    @(posedge clk); #1 rst = 1;
    @(negedge clk);
    checkOutput("post_rst_gnt", 32'(if_gnt), 32'd1);
    checkOutput("post_rst_addr", sram_addr, 32'h0000_0300);
    waitRvalid(1'b0);
    if_req = 0;

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arb.md
MEM_PORT_ARB -- requirements
Module: mem_port_arb

Interface
REQ-001 Parameter RD_LAT, default 2, meaning SRAM read latency in cycles from issue to sampled read data; legal range 1..7.
REQ-002 Parameter STARVE_MAX, default 4, meaning fetch-side lost-arbitration limit; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-low.
REQ-005 if_req  input  1  fetch request; held with if_addr until if_rvalid.
REQ-006 if_addr  input  32  fetch byte address.
REQ-007 if_gnt  output  1  one-cycle pulse in the fetch issue cycle.
REQ-008 if_rvalid  output  1  one-cycle pulse: fetch complete, if_rdata valid.
REQ-009 if_rdata  output  32  fetch data, registered, held until next fetch completion.
REQ-010 ls_req  input  1  load/store request; held with ls_we, ls_addr, ls_wdata until ls_rvalid.
REQ-011 ls_we  input  4  byte write enables; 4'b0000 means load.
REQ-012 ls_addr  input  32  load/store byte address.
REQ-013 ls_wdata  input  32  store data.
REQ-014 ls_gnt  output  1  one-cycle pulse in the load/store issue cycle.
REQ-015 ls_rvalid  output  1  one-cycle pulse: load/store complete, ls_rdata valid for loads.
REQ-016 ls_rdata  output  32  load data, registered, held until next load completion.
REQ-017 sram_en, sram_we[3:0], sram_addr[31:0], sram_wdata[31:0]  outputs  shared SRAM port, driven only in an issue cycle, zero otherwise.
REQ-018 sram_rdata  input  32  SRAM read data, valid RD_LAT cycles after issue.
REQ-019 stallreq_if, stallreq_ls  outputs  1 each  stall requests to the pipeline stall controller.

Function
REQ-020 FSM states: IDLE, WAIT, RESP; one transaction outstanding at a time.
REQ-021 IDLE: if any request, issue the winner combinationally (sram_* from winner, matching gnt pulse), latch owner, load wait counter with RD_LAT-1, go WAIT (loads) or RESP (stores).
REQ-022 WAIT: counter decrements each cycle; at counter 0, capture sram_rdata into the owner's rdata register, go RESP.
REQ-023 RESP: pulse owner's rvalid for exactly one cycle; no issue in this cycle; go IDLE.
REQ-024 Load latency: gnt at cycle T, rvalid at T+RD_LAT+1; store: gnt at T, rvalid at T+1.
REQ-025 Arbitration: ls_req wins over if_req when both are high in IDLE, except as in REQ-031.
REQ-026 stallreq_if = if_req & ~if_rvalid; stallreq_ls = ls_req & ~ls_rvalid.
REQ-027 A request dropped after grant does not abort; the transaction completes and rvalid still pulses.
REQ-028 Non-owner rdata registers and rvalid outputs are unchanged during another transaction.
REQ-029 Addresses are passed unmodified; no alignment checking.

Reset
REQ-030 While rst is low: state IDLE, counters 0, owner fetch, all gnt/rvalid/sram_* outputs 0, if_rdata and ls_rdata 32'h0; reset asserted mid-transaction abandons it with no rvalid pulse.

Configuration
REQ-031 ARB_STARVE_EN defined: a 4-bit starvation counter increments on each IDLE issue where if_req is high and ls wins, clears on fetch grant; when it equals STARVE_MAX, fetch wins the next contested arbitration.
REQ-032 ARB_STARVE_EN undefined: strict ls priority, no starvation counter in the design.

Verification
REQ-033 RD_LAT=2, if_req only, if_addr=32'h0000_0100, sram_rdata=32'hDEAD_BEEF at T+2 -> if_gnt at T, sram_addr=32'h0000_0100, if_rvalid and if_rdata=32'hDEAD_BEEF at T+3.
REQ-034 if_req and ls_req high together, ls_we=4'b0011, ls_wdata=32'h1234_5678 -> ls_gnt first with sram_we=4'b0011, ls_rvalid next cycle, if_gnt two cycles after ls_gnt.
REQ-035 ARB_STARVE_EN, STARVE_MAX=4, ls_req and if_req held high continuously -> four ls grants, then one if grant, pattern repeats; without macro -> zero if grants.
REQ-036 Load granted, ls_req dropped one cycle later -> ls_rvalid still pulses at T+RD_LAT+1, then stallreq_ls=0.
REQ-037 rst asserted low in WAIT -> next cycle state IDLE, all outputs 0, no rvalid; after release, pending if_req granted on first active edge.
